fc2_classify: RTL and testbench

Output stage of the digit classifier, directly downstream of the 128-neuron first fully-connected layer. On a start pulse it computes 10 class scores from that layer's 128-byte ReLU activation vector: per class, one weight row times the activations through the shared MultAdder, plus a per-class bias through Float8Adder. It then reports the arg-max digit and its score. Scores are compared on the fly, so the result is ready one cycle after the last class.

---
 rtl/fc2_classify_pkg.sv | 30 +++
 rtl/Float8Adder.sv | 27 ++
 rtl/fc2_argmax_cmp.sv | 28 ++
 rtl/fc2_classify.sv | 159 +++++++++++++++
 tb/tb_fc2_classify.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fc2_classify_pkg.sv
// Shared constants and FSM encoding for the FC2 classifier output stage.
// The ROM address constants are also consumed by the ROM image generator.
package fc2_classify_pkg;

  localparam int FC2_N_CLASS = 10;
  localparam int ACT_W       = 1024;
  localparam int SM_W        = 15;
  localparam logic [13:0] SM_MAX_MAG = 14'h3FFF;

  localparam logic [3:0] FC2_W_ADDR_BASE = 4'h0;
  localparam logic [3:0] FC2_B_ADDR      = 4'hA;

  typedef enum logic [3:0] {
    S_IDLE,
    S_B_ASK,
    S_B_GET,
    S_ASK,
    S_MUL,
    S_ACC,
    S_CMP,
    S_NEXT,
    S_DONE
  } state_t;

  // A bias byte sits in the top of the sign-magnitude score word.
  function automatic logic [SM_W-1:0] sm_widen_bias(input logic [7:0] b);
    return {b, 7'b0};
  endfunction

endpackage

// File: rtl/Float8Adder.sv
// 15-bit sign-magnitude adder shared with the rest of the classifier.
// Zero results are always returned as +0.
module Float8Adder (
  input  logic [14:0] a,
  input  logic [14:0] b,
  output logic [14:0] sum,
  output logic        overflow
);

  logic [14:0] mag_sum;

  always_comb begin
    mag_sum  = {1'b0, a[13:0]} + {1'b0, b[13:0]};
    sum      = '0;
    overflow = 1'b0;
    if (a[14] == b[14]) begin
      sum      = {a[14], mag_sum[13:0]};
      overflow = mag_sum[14];
    end else if (a[13:0] >= b[13:0]) begin
      sum = {a[14], a[13:0] - b[13:0]};
    end else begin
      sum = {b[14], b[13:0] - a[13:0]};
    end
    if (sum[13:0] == 14'd0) sum[14] = 1'b0;
  end

endmodule

// File: rtl/fc2_argmax_cmp.sv
// Combinational sign-magnitude "a > b"; +0 and -0 compare equal.
module fc2_argmax_cmp
  import fc2_classify_pkg::*;
(
  input  logic [SM_W-1:0] a,
  input  logic [SM_W-1:0] b,
  output logic            gt
);

  logic a_zero, b_zero;

  always_comb begin
    a_zero = (a[SM_W-2:0] == '0);
    b_zero = (b[SM_W-2:0] == '0);
    gt     = 1'b0;
    if (a_zero && b_zero)
      gt = 1'b0;
    else if (!a[SM_W-1] && b[SM_W-1])
      gt = 1'b1;
    else if (a[SM_W-1] && !b[SM_W-1])
      gt = 1'b0;
    else if (!a[SM_W-1])
      gt = (a[SM_W-2:0] > b[SM_W-2:0]);
    else
      gt = (a[SM_W-2:0] < b[SM_W-2:0]);
  end

endmodule

// File: rtl/fc2_classify.sv
// FC2 output stage: 10 class scores (weight row . activations + bias), running arg-max.
// Optional FC2_SATURATE_EN clamps overflowed scores to full-scale before the compare.
module fc2_classify
  import fc2_classify_pkg::*;
#(
  parameter logic [3:0] W_ADDR_BASE = FC2_W_ADDR_BASE,
  parameter logic [3:0] B_ADDR      = FC2_B_ADDR,
  parameter int         N_CLASS     = FC2_N_CLASS
) (
  input  logic             clk,
  input  logic             iRst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [ACT_W-1:0] fc1_act,
  input  logic [ACT_W-1:0] data_from_rom,
  input  logic [SM_W-1:0]  data_from_MultAdder,
  input  logic             overflow_from_MultAdder,
  output logic [3:0]       addr_to_rom,
  output logic [ACT_W-1:0] opr1_to_MultAdder,
  output logic [ACT_W-1:0] opr2_to_MultAdder,
  output logic             busy,
  output logic             done,
  output logic [3:0]       digit,
  output logic [SM_W-1:0]  max_score,
  output logic             overflow
);

  state_t           state;
  logic [3:0]       k;
  logic [7:0]       bias_byte [N_CLASS];
  logic [3:0]       addr_q;
  logic [ACT_W-1:0] opr1_q, opr2_q;
  logic [SM_W-1:0]  mult_p1, bias_p1;
  logic [SM_W-1:0]  add_sum_p2, score_p2, best;
  logic             add_ovf_p2, gt_p2;
  logic [3:0]       best_idx;
  logic             done_q, busy_q, ovf_q;
  logic [3:0]       digit_q;
  logic [SM_W-1:0]  max_q;

`ifdef FC2_SATURATE_EN
  logic ovf_cls_p1;

  function automatic logic [SM_W-1:0] sat_sm(input logic [SM_W-1:0] v, input logic ovf);
    return ovf ? {v[SM_W-1], SM_MAX_MAG} : v;
  endfunction
`endif

  // ---- p2: bias add and compare against the running best ----
  Float8Adder u_add (
    .a        (mult_p1),
    .b        (bias_p1),
    .sum      (add_sum_p2),
    .overflow (add_ovf_p2)
  );

`ifdef FC2_SATURATE_EN
  assign score_p2 = sat_sm(add_sum_p2, add_ovf_p2 | ovf_cls_p1);
`else
  assign score_p2 = add_sum_p2;
`endif

  fc2_argmax_cmp u_cmp (
    .a  (score_p2),
    .b  (best),
    .gt (gt_p2)
  );

  // ---- FSM: with ena low nothing moves, so the bus owner can change hands mid-run ----
  always_ff @(posedge clk) begin
    if (ena) begin
      if (!iRst_n) begin
        state   <= S_IDLE;
        k       <= '0;
        addr_q  <= '0;
        opr1_q  <= '0;
        opr2_q  <= '0;
        done_q  <= 1'b0;
        busy_q  <= 1'b0;
        digit_q <= '0;
        max_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              state  <= S_B_ASK;
              addr_q <= B_ADDR;
              done_q <= 1'b0;
              ovf_q  <= 1'b0;
              best   <= '0;
            end else if (state == S_DONE) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              digit_q <= best_idx;
              max_q   <= best;
            end
          end
          S_B_ASK: begin
            busy_q <= 1'b1;
            state  <= S_B_GET;
          end
          S_B_GET: begin
            for (int i = 0; i < N_CLASS; i++)
              bias_byte[i] <= data_from_rom[8*i +: 8];
            k      <= '0;
            addr_q <= W_ADDR_BASE;
            state  <= S_ASK;
          end
          S_ASK: state <= S_MUL;
          // ---- p0: operands registered toward the MultAdder ----
          S_MUL: begin
            opr1_q <= fc1_act;
            opr2_q <= data_from_rom;
            state  <= S_ACC;
          end
          // ---- p1: product and widened bias registered into the adder ----
          S_ACC: begin
            mult_p1 <= data_from_MultAdder;
            bias_p1 <= sm_widen_bias(bias_byte[k]);
            ovf_q   <= ovf_q | overflow_from_MultAdder;
`ifdef FC2_SATURATE_EN
            ovf_cls_p1 <= overflow_from_MultAdder;
`endif
            state   <= S_CMP;
          end
          S_CMP: begin
            ovf_q <= ovf_q | add_ovf_p2;
            if (k == 4'd0 || gt_p2) begin
              best     <= score_p2;
              best_idx <= k;
            end
            state <= S_NEXT;
          end
          S_NEXT: begin
            if (k == 4'(N_CLASS - 1)) begin
              state <= S_DONE;
            end else begin
              k      <= k + 4'd1;
              addr_q <= W_ADDR_BASE + k + 4'd1;
              state  <= S_ASK;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign addr_to_rom       = ena ? addr_q : 'z;
  assign opr1_to_MultAdder = ena ? opr1_q : 'z;
  assign opr2_to_MultAdder = ena ? opr2_q : 'z;
  assign busy              = busy_q;
  assign done              = done_q;
  assign digit             = digit_q;
  assign max_score         = max_q;
  assign overflow          = ovf_q;

endmodule

// File: tb/tb_fc2_classify.sv
// Self-checking bench for fc2_classify (define FC2_SATURATE_EN to check the clamping build).
module tb_fc2_classify;
  import fc2_classify_pkg::*;

  logic             clk = 1'b0;
  logic             iRst_n, ena, start;
  logic [ACT_W-1:0] fc1_act, data_from_rom;
  logic [SM_W-1:0]  data_from_MultAdder;
  logic             overflow_from_MultAdder;
  wire  [3:0]       addr_to_rom;
  wire  [ACT_W-1:0] opr1_to_MultAdder, opr2_to_MultAdder;
  logic             busy, done, overflow;
  logic [3:0]       digit;
  logic [SM_W-1:0]  max_score;

  logic [SM_W-1:0] cmp_a, cmp_b;
  logic            cmp_gt;

  fc2_classify dut (
    .clk                     (clk),
    .iRst_n                  (iRst_n),
    .ena                     (ena),
    .start                   (start),
    .fc1_act                 (fc1_act),
    .data_from_rom           (data_from_rom),
    .data_from_MultAdder     (data_from_MultAdder),
    .overflow_from_MultAdder (overflow_from_MultAdder),
    .addr_to_rom             (addr_to_rom),
    .opr1_to_MultAdder       (opr1_to_MultAdder),
    .opr2_to_MultAdder       (opr2_to_MultAdder),
    .busy                    (busy),
    .done                    (done),
    .digit                   (digit),
    .max_score               (max_score),
    .overflow                (overflow)
  );

  fc2_argmax_cmp u_cmp (.a(cmp_a), .b(cmp_b), .gt(cmp_gt));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Environment models: ROM with one-cycle latency, MultAdder keyed by the class tag in the weight row.
  logic [SM_W-1:0] mult_tab [16];
  logic            ovf_tab  [16];
  logic [79:0]     bias_vec;

  always_comb begin
    data_from_MultAdder     = mult_tab[opr2_to_MultAdder[3:0]];
    overflow_from_MultAdder = ovf_tab[opr2_to_MultAdder[3:0]];
  end

  always @(posedge clk) begin
    if (ena) begin
      if (addr_to_rom == FC2_B_ADDR)
        data_from_rom <= {944'b0, bias_vec};
      else
        data_from_rom <= {{127{8'h5A}}, 4'h0, addr_to_rom};
    end
  end

  typedef struct {
    logic [14:0] mult_def;
    logic [14:0] mult_sp;
    int          sp_cls;
    int          ovf_cls;
    logic [7:0]  bias_def;
    logic [7:0]  bias_sp;
    int          bias_cls;
    logic [3:0]  e_digit;
    logic [14:0] e_max;
    logic        e_ovf;
  } vec_t;

  typedef struct {
    logic [3:0]  d;
    logic [14:0] m;
    logic        o;
    int          lat;
    int          bsy;
  } exp_t;

  typedef struct {
    logic [14:0] a;
    logic [14:0] b;
    logic        gt;
  } cmp_vec_t;

  exp_t sb[$];

  task automatic configure(input vec_t v);
    for (int i = 0; i < 16; i++) begin
      mult_tab[i] = (i == v.sp_cls) ? v.mult_sp : v.mult_def;
      ovf_tab[i]  = (i == v.ovf_cls);
    end
    for (int i = 0; i < 10; i++)
      bias_vec[8*i +: 8] = (i == v.bias_cls) ? v.bias_sp : v.bias_def;
  endtask

  task automatic push_exp(input vec_t v, input int lat, input int bsy);
    exp_t e;
    e.d = v.e_digit; e.m = v.e_max; e.o = v.e_ovf; e.lat = lat; e.bsy = bsy;
    sb.push_back(e);
  endtask

  // One start pulse; edge 0 samples start, cyc counts the edges after it.
  task automatic run(input int freeze_at, input int rst_at, input bit expect_done);
    int   cyc = 0;
    int   bcnt = 0;
    bit   got = 0;
    exp_t e;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    while (cyc < 200 && !got) begin
      @(negedge clk);
      if (freeze_at >= 0) ena = !(cyc >= freeze_at && cyc < freeze_at + 3);
      if (rst_at >= 0) iRst_n = (cyc != rst_at);
      @(posedge clk); #1;
      cyc++;
      if (busy) bcnt++;
      if (cyc == 1) begin
        check("done_clr_on_start", done, 1'b0);
        check("ovf_clr_on_start", overflow, 1'b0);
        check("addr_bias", addr_to_rom, FC2_B_ADDR);
        check("busy_rise", busy, 1'b1);
      end
      if (cyc == 19 && freeze_at < 0 && rst_at < 0) begin
        check("addr_cls3", addr_to_rom, 4'd3);
        check("opr1_is_act", opr1_to_MultAdder === fc1_act, 1'b1);
        check("opr2_cls3_row", opr2_to_MultAdder[7:0], 8'd3);
      end
      if (!ena) begin
        check("addr_released", (addr_to_rom === 4'bz) || (addr_to_rom === 4'd0), 1'b1);
        check("opr1_released", (opr1_to_MultAdder === {ACT_W{1'bz}}) || (opr1_to_MultAdder == '0), 1'b1);
        check("opr2_released", (opr2_to_MultAdder === {ACT_W{1'bz}}) || (opr2_to_MultAdder == '0), 1'b1);
        check("frozen_busy", busy, 1'b1);
      end
      if (rst_at >= 0 && cyc == rst_at + 1) begin
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_digit", digit, 4'd0);
        check("rst_max", max_score, 15'd0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_addr", addr_to_rom, 4'd0);
        break;
      end
      if (done) got = 1'b1;
    end
    iRst_n = 1'b1;
    ena    = 1'b1;
    if (expect_done) begin
      check("done_seen", got, 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("digit", digit, e.d);
        check("max_score", max_score, e.m);
        check("overflow", overflow, e.o);
        check("done_latency", cyc, e.lat);
        check("busy_cycles", bcnt, e.bsy);
        repeat (3) @(posedge clk);
        #1;
        check("done_held", done, 1'b1);
        check("digit_held", digit, e.d);
        check("busy_low_after", busy, 1'b0);
      end else begin
        check("scoreboard_empty", 1'b1, 1'b0);
      end
    end
  endtask

  vec_t     vecs [6];
  cmp_vec_t cvecs [10];
  vec_t     base;

  initial begin
    iRst_n = 1'b0;
    ena    = 1'b1;
    start  = 1'b0;
    for (int i = 0; i < 32; i++) fc1_act[32*i +: 32] = $urandom | 32'h1;

    //            mult_def  mult_sp  sp  ovf  b_def  b_sp  b_cls  digit max      ovf
    vecs[0] = '{15'h0000, 15'h0000, 15, 15, 8'h08, 8'h10, 7,  4'd7, 15'h0800, 1'b0};
    vecs[1] = '{15'h0000, 15'h0000, 15, 15, 8'h05, 8'h05, 15, 4'd0, 15'h0280, 1'b0};
    vecs[2] = '{15'h4200, 15'h4100, 3,  15, 8'h00, 8'h00, 15, 4'd3, 15'h4100, 1'b0};
`ifdef FC2_SATURATE_EN
    vecs[3] = '{15'h0100, 15'h0050, 5,  5,  8'h00, 8'h00, 15, 4'd5, 15'h3FFF, 1'b1};
    vecs[4] = '{15'h0000, 15'h3F00, 2,  15, 8'h10, 8'h7F, 2,  4'd2, 15'h3FFF, 1'b1};
`else
    vecs[3] = '{15'h0100, 15'h0050, 5,  5,  8'h00, 8'h00, 15, 4'd0, 15'h0100, 1'b1};
    vecs[4] = '{15'h0000, 15'h3F00, 2,  15, 8'h10, 8'h7F, 2,  4'd2, 15'h3E80, 1'b1};
`endif
    vecs[5] = '{15'h0300, 15'h0300, 15, 15, 8'h84, 8'h02, 9,  4'd9, 15'h0400, 1'b0};

    cvecs[0] = '{15'h0000, 15'h4000, 1'b0};
    cvecs[1] = '{15'h4000, 15'h0000, 1'b0};
    cvecs[2] = '{15'h0001, 15'h4000, 1'b1};
    cvecs[3] = '{15'h4001, 15'h0000, 1'b0};
    cvecs[4] = '{15'h0005, 15'h0003, 1'b1};
    cvecs[5] = '{15'h0003, 15'h0005, 1'b0};
    cvecs[6] = '{15'h4003, 15'h4005, 1'b1};
    cvecs[7] = '{15'h4005, 15'h4003, 1'b0};
    cvecs[8] = '{15'h0100, 15'h0100, 1'b0};
    cvecs[9] = '{15'h0000, 15'h4001, 1'b1};

    for (int i = 0; i < 10; i++) begin
      cmp_a = cvecs[i].a;
      cmp_b = cvecs[i].b;
      #1;
      check($sformatf("cmp_gt[%0d]", i), cmp_gt, cvecs[i].gt);
    end

    configure(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", done, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_digit", digit, 4'd0);
    check("reset_max", max_score, 15'd0);
    check("reset_ovf", overflow, 1'b0);
    check("reset_addr", addr_to_rom, 4'd0);
    check("reset_opr1", opr1_to_MultAdder == '0, 1'b1);
    @(negedge clk); iRst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int t = 0; t < 6; t++) begin
      configure(vecs[t]);
      push_exp(vecs[t], 53, 52);
      run(-1, -1, 1'b1);
    end

    base = vecs[0];
    configure(base);
    run(-1, 24, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle_busy", busy, 1'b0);
    push_exp(base, 53, 52);
    run(-1, -1, 1'b1);

    push_exp(base, 56, 55);
    run(23, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
